// File: rtl/complex_mag_stream_div_pkg.sv
// Shared types and helpers for the complex_mag_stream iterative divider.
//   div_state_e  : divider FSM states
//   Def*Width    : default operand/result widths (50 / 6 / 44)
//   div_step()   : one restoring-division step at the default divisor width
package complex_mag_stream_div_pkg;

  localparam int unsigned DefDividendWidth = 50;
  localparam int unsigned DefDivisorWidth  = 6;
  localparam int unsigned DefQuotientWidth = 44;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } div_state_e;

  typedef struct packed {
    logic [DefDivisorWidth:0] rem;
    logic                     q;
  } div_step_t;

  // Shift one dividend bit into the partial remainder and try to subtract the divisor.
  // The extra MSB of the trial difference is its sign: set means "restore".
  function automatic div_step_t div_step(input logic [DefDivisorWidth:0]   rem,
                                         input logic                       din,
                                         input logic [DefDivisorWidth-1:0] divisor);
    logic [DefDivisorWidth+1:0] shifted;
    logic [DefDivisorWidth+1:0] trial;
    div_step_t                  res;
    shifted = {rem, din};
    trial   = shifted - {2'b00, divisor};
    res.q   = ~trial[DefDivisorWidth+1];
    res.rem = res.q ? trial[DefDivisorWidth:0] : shifted[DefDivisorWidth:0];
    return res;
  endfunction

endpackage

// File: rtl/complex_mag_stream_div_step.sv
// Single restoring-division step (combinational), reused every iteration.
//   rem      : current partial remainder (DIVISOR_WIDTH+1 bits, always < divisor)
//   din      : next dividend bit, MSB first
//   divisor  : non-zero divisor
//   rem_next : partial remainder after the step
//   q_bit    : quotient bit produced by the step
module complex_mag_stream_div_step #(
  parameter int unsigned DIVISOR_WIDTH = 6
) (
  input  logic [DIVISOR_WIDTH:0]   rem,
  input  logic                     din,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  output logic [DIVISOR_WIDTH:0]   rem_next,
  output logic                     q_bit
);

  logic [DIVISOR_WIDTH+1:0] shifted;
  logic [DIVISOR_WIDTH+1:0] trial;

  // Two guard bits: shifted < 2^(W+1), so the difference fits a (W+2)-bit signed value.
  always_comb begin
    shifted  = {rem, din};
    trial    = shifted - {2'b00, divisor};
    q_bit    = ~trial[DIVISOR_WIDTH+1];
    rem_next = q_bit ? trial[DIVISOR_WIDTH:0] : shifted[DIVISOR_WIDTH:0];
  end

endmodule

// File: rtl/complex_mag_stream_udiv_50ns_6ns_44_seq.sv
// Iterative unsigned divider: DIVIDEND_WIDTH-bit dividend / DIVISOR_WIDTH-bit divisor,
// one quotient bit per enabled cycle, one operation in flight.
//   ap_clk, ap_rst_n      : clock, asynchronous active-low reset
//   ce                    : clock enable, 0 freezes all state
//   in_valid / in_ready   : operand handshake (dividend, divisor)
//   out_valid / out_ready : result handshake (quotient, remainder, ovf, dbz)
//   quotient saturates to all-ones on overflow or divide-by-zero.
module complex_mag_stream_udiv_50ns_6ns_44_seq
  import complex_mag_stream_div_pkg::*;
#(
  parameter int unsigned DIVIDEND_WIDTH = DefDividendWidth,
  parameter int unsigned DIVISOR_WIDTH  = DefDivisorWidth,
  parameter int unsigned QUOTIENT_WIDTH = DefQuotientWidth
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      ce,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOTIENT_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      ovf,
  output logic                      dbz
);

  localparam int unsigned CntWidth = $clog2(DIVIDEND_WIDTH);
  localparam logic [CntWidth-1:0] LastStep = CntWidth'(DIVIDEND_WIDTH - 1);

  div_state_e                state_q, state_d;
  logic [CntWidth-1:0]       cnt_q, cnt_d;
  logic [DIVIDEND_WIDTH-1:0] dvd_q, dvd_d;
  logic [DIVISOR_WIDTH-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_WIDTH:0]    prem_q, prem_d;
  logic [DIVIDEND_WIDTH-1:0] fquot_q, fquot_d;
  logic [QUOTIENT_WIDTH-1:0] quot_q, quot_d;
  logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
  logic                      ovf_q, ovf_d;
  logic                      dbz_q, dbz_d;
  logic                      in_ready_q, in_ready_d;

  logic [DIVISOR_WIDTH:0]    step_rem;
  logic                      step_q;
  logic [DIVIDEND_WIDTH-1:0] fquot_next;
  logic                      ovf_next;

  complex_mag_stream_div_step #(
    .DIVISOR_WIDTH(DIVISOR_WIDTH)
  ) u_step (
    .rem      (prem_q),
    .din      (dvd_q[DIVIDEND_WIDTH-1]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // Any set bit above the output width means the quotient does not fit.
  assign fquot_next = (fquot_q << 1) | DIVIDEND_WIDTH'(step_q);
  assign ovf_next   = |(fquot_next >> QUOTIENT_WIDTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    fquot_d = fquot_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          cnt_d   = '0;
          prem_d  = '0;
          fquot_d = '0;
          if (divisor == '0) begin
            state_d = StDone;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            quot_d  = '1;
            rem_d   = dividend[DIVISOR_WIDTH-1:0];
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        prem_d  = step_rem;
        fquot_d = fquot_next;
        dvd_d   = dvd_q << 1;
        cnt_d   = cnt_q + CntWidth'(1);
        if (cnt_q == LastStep) begin
          state_d = StDone;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          ovf_d   = ovf_next;
          quot_d  = ovf_next ? '1 : fquot_next[QUOTIENT_WIDTH-1:0];
          // Top bit of the partial remainder is always 0 once a step completes.
          rem_d   = step_rem[DIVISOR_WIDTH-1:0];
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    in_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      prem_q     <= '0;
      fquot_q    <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      ovf_q      <= 1'b0;
      dbz_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else if (ce) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      prem_q     <= prem_d;
      fquot_q    <= fquot_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      ovf_q      <= ovf_d;
      dbz_q      <= dbz_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == StDone);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_complex_mag_stream_udiv_50ns_6ns_44_seq.sv
// Scoreboard bench for the iterative divider: expected results are computed with native
// division when operands are driven and compared when the result is presented.
module tb_complex_mag_stream_udiv_50ns_6ns_44_seq;

  localparam int unsigned DvdW = 50;
  localparam int unsigned DvsW = 6;
  localparam int unsigned QW   = 44;

  typedef struct {
    logic [QW-1:0]   q;
    logic [DvsW-1:0] r;
    logic            ovf;
    logic            dbz;
    int              lat;
  } exp_t;

  logic            ap_clk;
  logic            ap_rst_n;
  logic            ce;
  logic            in_valid;
  logic            in_ready;
  logic [DvdW-1:0] dividend;
  logic [DvsW-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [QW-1:0]   quotient;
  logic [DvsW-1:0] remainder;
  logic            ovf;
  logic            dbz;

  exp_t sb[$];
  int   n_vectors;
  int   n_miscompares;

  complex_mag_stream_udiv_50ns_6ns_44_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic exp_t model(input logic [DvdW-1:0] a, input logic [DvsW-1:0] b,
                                 input int stall);
    exp_t            e;
    logic [63:0]     qf;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a[DvsW-1:0];
      e.ovf = 1'b0;
      e.dbz = 1'b1;
      e.lat = 1 + stall;
    end else begin
      qf    = 64'(a) / 64'(b);
      e.r   = DvsW'(64'(a) % 64'(b));
      e.ovf = (qf >= (64'd1 << QW));
      e.q   = e.ovf ? '1 : qf[QW-1:0];
      e.dbz = 1'b0;
      e.lat = DvdW + 1 + stall;
    end
    return e;
  endfunction

  // One complete operation: ce=0 for `stall` cycles while busy, out_ready=0 for `hold`
  // cycles once the result is up (with a competing in_valid that must be ignored).
  task automatic run_op(input logic [DvdW-1:0] a, input logic [DvsW-1:0] b,
                        input int stall, input int hold);
    exp_t e;
    int   lat;
    int   w;
    w = 0;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    check_val("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b, stall));
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 300) begin
      ce = !(lat >= 10 && lat < 10 + stall);
      tick();
      lat++;
    end
    ce = 1'b1;
    check_val("sb_nonempty", 64'(sb.size()), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check_val("latency", 64'(lat), 64'(e.lat));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      dividend = a ^ 50'h155;
      divisor  = b ^ 6'h1;
      tick();
      check_val("hold_in_ready", 64'(in_ready), 64'd0);
      check_val("hold_valid", 64'(out_valid), 64'd1);
      check_val("hold_quotient", 64'(quotient), 64'(e.q));
    end
    in_valid = 1'b0;
    check_val("out_valid", 64'(out_valid), 64'd1);
    check_val("quotient", 64'(quotient), 64'(e.q));
    check_val("remainder", 64'(remainder), 64'(e.r));
    check_val("ovf", 64'(ovf), 64'(e.ovf));
    check_val("dbz", 64'(dbz), 64'(e.dbz));
    // ce low blocks the result handshake
    ce        = 1'b0;
    out_ready = 1'b1;
    tick();
    check_val("ce_blocks_done", 64'(out_valid), 64'd1);
    ce = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("valid_drop", 64'(out_valid), 64'd0);
    check_val("ready_back", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] rnd;
    n_vectors     = 0;
    n_miscompares = 0;
    ap_rst_n      = 1'b0;
    ce            = 1'b1;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    dividend      = '0;
    divisor       = '0;
    tick();
    tick();
    check_val("rst_in_ready", 64'(in_ready), 64'd0);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_quotient", 64'(quotient), 64'd0);
    check_val("rst_remainder", 64'(remainder), 64'd0);
    check_val("rst_ovf", 64'(ovf), 64'd0);
    check_val("rst_dbz", 64'(dbz), 64'd0);
    ap_rst_n = 1'b1;
    tick();
    check_val("post_rst_ready", 64'(in_ready), 64'd1);

    run_op(50'd1000, 6'd7, 0, 0);
    run_op(50'd1108307720798207, 6'd63, 0, 0);
    run_op({DvdW{1'b1}}, 6'd63, 0, 0);
    run_op(50'h123, 6'd0, 0, 0);
    run_op(50'd987654321, 6'd13, 0, 20);
    run_op(50'd555555555555, 6'd9, 5, 3);
    run_op(50'd5, 6'd1, 0, 0);
    run_op(50'd0, 6'd3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      rnd = {$urandom, $urandom};
      run_op(rnd[DvdW-1:0], 6'($urandom_range(1, 63)), 0, 0);
    end

    // Abort mid-busy: quotient currently holds the previous (non-zero) result.
    run_op(50'd4000, 6'd3, 0, 0);
    in_valid = 1'b1;
    dividend = 50'd1000;
    divisor  = 6'd7;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    ap_rst_n = 1'b0;
    #1;
    check_val("abort_valid", 64'(out_valid), 64'd0);
    check_val("abort_quotient", 64'(quotient), 64'd0);
    check_val("abort_ready", 64'(in_ready), 64'd0);
    tick();
    ap_rst_n = 1'b1;
    tick();
    check_val("abort_ready_back", 64'(in_ready), 64'd1);
    run_op(50'd50, 6'd5, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
